// File: rtl/io_port_unit.sv
// io_port_unit: bridges processor IN/OUT instructions to an external device.
// OUT words are queued in a small FIFO; IN words come from a one-entry holding register.
//
// Ports:
//   clk, reset                      clock; asynchronous active-low reset
//   out_req, out_data, out_stall    processor OUT request, word, stall
//   in_req, in_data, in_stall       processor IN request, word, stall
//   port_out_valid/data/ready       device-side output handshake
//   port_in_valid/data/ready        device-side input handshake
//   out_count                       output FIFO occupancy
module io_port_unit #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         out_req,
    input  logic [DATA_W-1:0]            out_data,
    output logic                         out_stall,
    input  logic                         in_req,
    output logic [DATA_W-1:0]            in_data,
    output logic                         in_stall,
    output logic                         port_out_valid,
    output logic [DATA_W-1:0]            port_out_data,
    input  logic                         port_out_ready,
    input  logic                         port_in_valid,
    input  logic [DATA_W-1:0]            port_in_data,
    output logic                         port_in_ready,
    output logic [$clog2(OUT_DEPTH):0]   out_count
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(OUT_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    // Output FIFO state
    logic [DATA_W-1:0] mem [OUT_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              push;
    logic              pop;

    // Input holding register state
    logic              in_full;
    logic [DATA_W-1:0] in_reg;
    logic              load;
    logic              consume;

    // A full FIFO refuses the push even when a pop fires this cycle,
    // which keeps out_stall free of any path from port_out_ready.
    assign full      = (count == FULL_CNT);
    assign push      = out_req && !full;
    assign pop       = port_out_valid && port_out_ready;
    assign out_stall = out_req && full;

    assign port_out_valid = (count != '0);
    assign port_out_data  = mem[rd_ptr];
    assign out_count      = count;

    assign port_in_ready = !in_full;
    assign load          = port_in_valid && !in_full;
    assign consume       = in_req && in_full;
    assign in_stall      = in_req && !in_full;
    assign in_data       = in_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= out_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            unique case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // Load and consume are mutually exclusive: loading needs !in_full,
    // consuming needs in_full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_full <= 1'b0;
            in_reg  <= '0;
        end else if (load) begin
            in_full <= 1'b1;
            in_reg  <= port_in_data;
        end else if (consume) begin
            in_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit: directed self-checking bench for io_port_unit.
// Inputs driven 1 time unit after the rising edge; outputs sampled after settling.
module tb_io_port_unit;

    logic        clk;
    logic        reset;
    logic        out_req;
    logic [15:0] out_data;
    logic        out_stall;
    logic        in_req;
    logic [15:0] in_data;
    logic        in_stall;
    logic        port_out_valid;
    logic [15:0] port_out_data;
    logic        port_out_ready;
    logic        port_in_valid;
    logic [15:0] port_in_data;
    logic        port_in_ready;
    logic [2:0]  out_count;

    int vectors = 0;
    int errors  = 0;

    io_port_unit #(.DATA_W(16), .OUT_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .out_req        (out_req),
        .out_data       (out_data),
        .out_stall      (out_stall),
        .in_req         (in_req),
        .in_data        (in_data),
        .in_stall       (in_stall),
        .port_out_valid (port_out_valid),
        .port_out_data  (port_out_data),
        .port_out_ready (port_out_ready),
        .port_in_valid  (port_in_valid),
        .port_in_data   (port_in_data),
        .port_in_ready  (port_in_ready),
        .out_count      (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        out_req        = 1'b0;
        out_data       = '0;
        in_req         = 1'b1;
        port_out_ready = 1'b0;
        port_in_valid  = 1'b0;
        port_in_data   = '0;
        #1;
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ovalid", 32'(port_out_valid), 32'd0);
        chk("rst_odata", 32'(port_out_data), 32'h0);
        chk("rst_indata", 32'(in_data), 32'h0);
        chk("rst_iready", 32'(port_in_ready), 32'd1);
        chk("rst_ostall", 32'(out_stall), 32'd0);
        chk("rst_istall", 32'(in_stall), 32'd1);
        in_req = 1'b0;
        #1;
        reset = 1'b1;

        // Fill three words with the device stalled
        tick();
        out_req = 1'b1;
        out_data = 16'h00A1;
        tick();
        out_data = 16'h00A2;
        tick();
        out_data = 16'h00A3;
        #1;
        chk("fill_stall2", 32'(out_stall), 32'd0);
        tick();
        chk("fill_count3", 32'(out_count), 32'd3);
        chk("fill_head", 32'(port_out_data), 32'h00A1);
        chk("fill_valid", 32'(port_out_valid), 32'd1);
        chk("fill_stall3", 32'(out_stall), 32'd0);

        // Fill to four, then push against a full FIFO while it drains
        out_data = 16'h00A4;
        tick();
        chk("full_count", 32'(out_count), 32'd4);
        out_data = 16'h00FF;
        port_out_ready = 1'b1;
        #1;
        chk("full_stall", 32'(out_stall), 32'd1);
        tick();
        chk("full_pop_cnt", 32'(out_count), 32'd3);
        chk("head_a2", 32'(port_out_data), 32'h00A2);
        chk("retry_stall", 32'(out_stall), 32'd0);
        tick();
        out_req = 1'b0;
        chk("retry_cnt", 32'(out_count), 32'd3);
        chk("head_a3", 32'(port_out_data), 32'h00A3);
        tick();
        chk("head_a4", 32'(port_out_data), 32'h00A4);
        chk("drain_cnt2", 32'(out_count), 32'd2);
        tick();
        chk("head_ff", 32'(port_out_data), 32'h00FF);
        chk("drain_cnt1", 32'(out_count), 32'd1);
        tick();
        chk("drain_cnt0", 32'(out_count), 32'd0);
        chk("drain_valid", 32'(port_out_valid), 32'd0);

        // Streaming push and pop, crossing the pointer wrap
        out_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            out_data = 16'(i);
            #1;
            chk("strm_stall", 32'(out_stall), 32'd0);
            tick();
            chk("strm_count", 32'(out_count), 32'd1);
            chk("strm_head", 32'(port_out_data), 32'(i));
        end
        out_req = 1'b0;
        tick();
        chk("strm_empty", 32'(out_count), 32'd0);
        port_out_ready = 1'b0;

        // IN with no data held, then device fills
        in_req = 1'b1;
        #1;
        chk("in_stall_empty", 32'(in_stall), 32'd1);
        chk("in_ready_empty", 32'(port_in_ready), 32'd1);
        port_in_valid = 1'b1;
        port_in_data = 16'h1234;
        #1;
        chk("in_no_bypass", 32'(in_stall), 32'd1);
        tick();
        port_in_valid = 1'b0;
        chk("in_stall_load", 32'(in_stall), 32'd0);
        chk("in_data_1234", 32'(in_data), 32'h1234);
        chk("in_ready_full", 32'(port_in_ready), 32'd0);
        tick();
        chk("in_ready_cons", 32'(port_in_ready), 32'd1);
        chk("in_stall_cons", 32'(in_stall), 32'd1);
        chk("in_data_keep", 32'(in_data), 32'h1234);
        in_req = 1'b0;

        // Held word blocks a second offer until consumed
        port_in_valid = 1'b1;
        port_in_data = 16'h5555;
        tick();
        port_in_data = 16'h6666;
        #1;
        chk("hold_ready", 32'(port_in_ready), 32'd0);
        tick();
        chk("hold_data", 32'(in_data), 32'h5555);
        in_req = 1'b1;
        #1;
        chk("hold_istall", 32'(in_stall), 32'd0);
        tick();
        in_req = 1'b0;
        chk("hold_cons_rdy", 32'(port_in_ready), 32'd1);
        chk("hold_cons_dat", 32'(in_data), 32'h5555);
        tick();
        port_in_valid = 1'b0;
        chk("load_6666", 32'(in_data), 32'h6666);
        chk("load_6666_rdy", 32'(port_in_ready), 32'd0);

        // Mid-operation asynchronous reset
        out_req = 1'b1;
        out_data = 16'h0011;
        tick();
        out_data = 16'h0022;
        tick();
        out_req = 1'b0;
        chk("pre_rst_cnt", 32'(out_count), 32'd2);
        chk("pre_rst_rdy", 32'(port_in_ready), 32'd0);
        #2;
        out_req = 1'b1;
        in_req = 1'b1;
        reset = 1'b0;
        #1;
        chk("arst_count", 32'(out_count), 32'd0);
        chk("arst_ovalid", 32'(port_out_valid), 32'd0);
        chk("arst_odata", 32'(port_out_data), 32'h0);
        chk("arst_indata", 32'(in_data), 32'h0);
        chk("arst_iready", 32'(port_in_ready), 32'd1);
        chk("arst_ostall", 32'(out_stall), 32'd0);
        chk("arst_istall", 32'(in_stall), 32'd1);
        out_req = 1'b0;
        in_req = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        chk("post_count", 32'(out_count), 32'd0);
        chk("post_iready", 32'(port_in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
